sa_ram_rwsp_be_param: RTL

- Parametrised 1-read/1-write scratchpad RAM for the systolic-array buffers; next generation of the fixed-size rwsp models.
- Keeps the two-stage read: the address register is loaded on re and the output register on ore.
- Adds byte-lane write enables, an optional write-to-read bypass, an output valid flag and an optional zero-initialisation sweep after reset.
- Sits between the array feeders and the on-chip buffer controllers; FPGA behavioural model, synthesisable.

---
 rtl/sa_ram_pkg.sv | 30 +++
 rtl/sa_ram_init_seq.sv | 56 +++++
 rtl/sa_ram_rwsp_be_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sa_ram_pkg.sv
// Shared types and helpers for the systolic-array scratchpad RAM family.
// be_merge works on a fixed maximum width; callers zero-extend and truncate.
package sa_ram_pkg;

    localparam int SA_RAM_PD_W   = 32;
    localparam int SA_RAM_MAX_W  = 4096;
    localparam int SA_RAM_MAX_BE = SA_RAM_MAX_W / 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sa_ram_state_e;

    // Enabled lanes come from new_word, all other lanes keep old_word.
    function automatic logic [SA_RAM_MAX_W-1:0] be_merge(
        input logic [SA_RAM_MAX_W-1:0]  old_word,
        input logic [SA_RAM_MAX_W-1:0]  new_word,
        input logic [SA_RAM_MAX_BE-1:0] be
    );
        logic [SA_RAM_MAX_W-1:0] res;
        res = old_word;
        for (int i = 0; i < SA_RAM_MAX_BE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sa_ram_init_seq.sv
// INIT/RUN sequencer: after reset, optionally sweeps every address once with a
// zero write, then hands the write port back to the user.
module sa_ram_init_seq
    import sa_ram_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int AW            = $clog2(DEPTH),
    parameter int INIT_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          init_busy,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output sa_ram_state_e state
);

    logic [AW-1:0] cnt;

    // busy is registered alongside the state so it is a clean flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            if (INIT_ON_RESET != 0) begin
                state     <= ST_INIT;
                init_busy <= 1'b1;
            end else begin
                state     <= ST_RUN;
                init_busy <= 1'b0;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == AW'(DEPTH - 1)) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                ST_RUN: begin
                    init_busy <= 1'b0;
                end
                default: begin
                    state     <= ST_RUN;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

    assign init_we   = init_busy;
    assign init_addr = cnt;

endmodule

// File: rtl/sa_ram_rwsp_be_param.sv
// Parametrised 1R/1W scratchpad: byte-lane writes, two-stage registered read
// (address on re, data on ore), optional write bypass and zero-init sweep.
module sa_ram_rwsp_be_param
    import sa_ram_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int WIDTH         = 256,
    parameter int AW            = $clog2(DEPTH),
    parameter int NBE           = WIDTH / 8,
    parameter int BYPASS        = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [AW-1:0]          ra,
    input  logic                   re,
    input  logic                   ore,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_vld,
    input  logic [AW-1:0]          wa,
    input  logic                   we,
    input  logic [NBE-1:0]         wbe,
    input  logic [WIDTH-1:0]       di,
    output logic                   init_busy,
    input  logic [SA_RAM_PD_W-1:0] pwrbus_ram_pd
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             init_we;
    logic [AW-1:0]    init_addr;
    sa_ram_state_e    unused_seq_state;
    logic             unused_pd;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [NBE-1:0]   wr_be;
    logic [WIDTH-1:0] wr_data;
    logic             wr_in_range;

    logic [AW-1:0]    ra_d;
    logic             vld1;
    logic [WIDTH-1:0] rd_word;
    logic             bypass_hit;
    logic [WIDTH-1:0] stage2_word;

    assign unused_pd = ^pwrbus_ram_pd;

    sa_ram_init_seq #(
        .DEPTH         (DEPTH),
        .AW            (AW),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_addr (init_addr),
        .state     (unused_seq_state)
    );

    // The sweep owns the write port outright; user writes are dropped meanwhile.
    always_comb begin
        wr_en   = we;
        wr_addr = wa;
        wr_be   = wbe;
        wr_data = di;
        if (init_busy) begin
            wr_en   = init_we;
            wr_addr = init_addr;
            wr_be   = '1;
            wr_data = '0;
        end
    end

    assign wr_in_range = (int'(wr_addr) < DEPTH);

    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            for (int i = 0; i < NBE; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (int'(ra_d) < DEPTH) begin
            rd_word = mem[ra_d];
        end
    end

    assign bypass_hit = (BYPASS != 0) && we && !init_busy &&
                        (wa == ra_d) && (int'(wa) < DEPTH);

    always_comb begin
        stage2_word = rd_word;
        if (bypass_hit) begin
            stage2_word = WIDTH'(be_merge(SA_RAM_MAX_W'(rd_word),
                                          SA_RAM_MAX_W'(di),
                                          SA_RAM_MAX_BE'(wbe)));
        end
    end

    // Stage 1: address register; vld1 is sticky once any read has been issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            ra_d <= '0;
            vld1 <= 1'b0;
        end else if (!init_busy && re) begin
            ra_d <= ra;
            vld1 <= 1'b1;
        end
    end

    // Stage 2: output register samples the pre-edge array contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (!init_busy && ore) begin
            dout     <= stage2_word;
            dout_vld <= vld1;
        end
    end

endmodule
